// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution filter array.
//   - default geometry / width parameters
//   - group-tracking FSM state type
//   - requant(): arithmetic shift, optional ReLU, saturation to a signed
//     element of data_w bits. Works on a wide signed value so any
//     ACC_W/DATA_W pair up to 64 bits can share one implementation; callers
//     truncate the (already saturated) result to DATA_W.
package conv_pkg;

    localparam int DEF_NUM_PE  = 16;
    localparam int DEF_WIN     = 27;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_SHIFT_W = 5;

    typedef logic signed [DEF_DATA_W-1:0] elem_t;

    typedef enum logic {
        GRP_IDLE = 1'b0,
        GRP_OPEN = 1'b1
    } grp_state_e;

    function automatic logic signed [63:0] requant(
        input logic signed [63:0] acc,
        input int                 shift,
        input logic               relu,
        input int                 data_w
    );
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        y  = acc >>> shift;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (relu && (y < 64'sd0)) begin
            y = 64'sd0;
        end
        if (y > hi) begin
            y = hi;
        end else if (y < lo) begin
            y = lo;
        end
        return y;
    endfunction

endpackage

// File: rtl/conv_pe.sv
// conv_pe: one filter processing element of the systolic chain.
//   Holds a runtime-loadable weight window, a window/flag pass-through
//   register (one pipeline stage) and a signed accumulator.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   en_i                pipeline advance (low = frozen by output stall)
//   w_we_i, w_data_i    weight write (already qualified by the top)
//   in_valid_i/first/last/data  window arriving from the previous stage
//   out_valid_o/first/last/data window held in this stage (to next PE)
//   acc_o               accumulator; updated from the window held here
module conv_pe #(
    parameter int WIN    = 27,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic                     w_we_i,
    input  logic [WIN*DATA_W-1:0]    w_data_i,
    input  logic                     in_valid_i,
    input  logic                     in_first_i,
    input  logic                     in_last_i,
    input  logic [WIN*DATA_W-1:0]    in_data_i,
    output logic                     out_valid_o,
    output logic                     out_first_o,
    output logic                     out_last_o,
    output logic [WIN*DATA_W-1:0]    out_data_o,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic [WIN*DATA_W-1:0]   w_q, w_d;
    logic [WIN*DATA_W-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] prod;

    // Dot product of the window held in this stage with the weights.
    always_comb begin
        prod = '0;
        for (int i = 0; i < WIN; i++) begin
            prod = prod + ACC_W'($signed(data_q[i*DATA_W +: DATA_W]))
                        * ACC_W'($signed(w_q[i*DATA_W +: DATA_W]));
        end
    end

    always_comb begin
        w_d     = w_q;
        data_d  = data_q;
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;
        acc_d   = acc_q;
        if (w_we_i) begin
            w_d = w_data_i;
        end
        if (en_i) begin
            valid_d = in_valid_i;
            first_d = in_first_i;
            last_d  = in_last_i;
            data_d  = in_data_i;
            if (valid_q) begin
                acc_d = first_q ? prod : acc_q + prod;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            w_q     <= w_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            acc_q   <= acc_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_first_o = first_q;
    assign out_last_o  = last_q;
    assign out_data_o  = data_q;
    assign acc_o       = acc_q;

endmodule

// File: rtl/conv_filter_array.sv
// conv_filter_array: NUM_PE filters chained along a window pipeline.
//   Accumulates dot products over channel groups, deskews the per-filter
//   sums so all lanes align, requantises and presents one result vector.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   w_we_i, w_sel_i, w_data_i     weight load (ignored + error while busy)
//   cfg_shift_i, cfg_relu_i       requant config, stable while busy_o
//   in_valid_i/in_ready_o, in_data_i, in_first_i, in_last_i   windows
//   out_valid_o/out_ready_i, out_data_o (lane k = filter k)    results
//   busy_o                        window, open group or result in flight
//   err_o                         sticky protocol error
//   dbg_state_o                   group FSM state
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A result stays on out_data_o unchanged until taken. The only
// backpressure source is an untaken result; it freezes the whole array, so
// in_ready_o = ~(out_valid_o & ~out_ready_i).
module conv_filter_array
    import conv_pkg::*;
#(
    parameter int NUM_PE  = DEF_NUM_PE,
    parameter int WIN     = DEF_WIN,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    localparam int SEL_W  = $clog2(NUM_PE)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       w_we_i,
    input  logic [SEL_W-1:0]           w_sel_i,
    input  logic [WIN*DATA_W-1:0]      w_data_i,
    input  logic [SHIFT_W-1:0]         cfg_shift_i,
    input  logic                       cfg_relu_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIN*DATA_W-1:0]      in_data_i,
    input  logic                       in_first_i,
    input  logic                       in_last_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [NUM_PE*DATA_W-1:0]   out_data_o,
    output logic                       busy_o,
    output logic                       err_o,
    output grp_state_e                 dbg_state_o
);

    grp_state_e               state_q, state_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;
    logic                     out_valid_q, out_valid_d;
    logic [NUM_PE*DATA_W-1:0] out_data_q, out_data_d;

    logic stall, en, accept, eff_first, busy, w_write;

    // Window chain: index 0 is the accepted input, index k+1 leaves PE k.
    logic                    ch_valid [NUM_PE+1];
    logic                    ch_first [NUM_PE+1];
    logic                    ch_last  [NUM_PE+1];
    logic [WIN*DATA_W-1:0]   ch_data  [NUM_PE+1];
    logic signed [ACC_W-1:0] acc      [NUM_PE];
    logic signed [ACC_W-1:0] aligned  [NUM_PE];
    logic [NUM_PE-1:0]       pe_valid;
    logic                    unused_tail;

    assign stall     = out_valid_q & ~out_ready_i;
    assign en        = ~stall;
    assign accept    = in_valid_i & en;
    // A window arriving with no group open always starts a fresh group.
    assign eff_first = in_first_i | (state_q == GRP_IDLE);
    assign busy      = (|pe_valid) | done_q | out_valid_q | (state_q == GRP_OPEN);
    assign w_write   = w_we_i & ~busy;

    assign ch_valid[0] = accept;
    assign ch_first[0] = eff_first;
    assign ch_last[0]  = in_last_i;
    assign ch_data[0]  = in_data_i;

    for (genvar k = 0; k < NUM_PE; k++) begin : g_lane
        localparam int DLY = NUM_PE - 1 - k;

        conv_pe #(
            .WIN    (WIN),
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_pe (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .en_i        (en),
            .w_we_i      (w_write && (32'(w_sel_i) == k)),
            .w_data_i    (w_data_i),
            .in_valid_i  (ch_valid[k]),
            .in_first_i  (ch_first[k]),
            .in_last_i   (ch_last[k]),
            .in_data_i   (ch_data[k]),
            .out_valid_o (ch_valid[k+1]),
            .out_first_o (ch_first[k+1]),
            .out_last_o  (ch_last[k+1]),
            .out_data_o  (ch_data[k+1]),
            .acc_o       (acc[k])
        );

        assign pe_valid[k] = ch_valid[k+1];

        // PE k's sum is final one cycle after the window leaves it, i.e.
        // NUM_PE-1-k cycles before the last PE's; sampling the accumulator
        // every enabled cycle through DLY registers lines all lanes up.
        if (DLY == 0) begin : g_nodly
            assign aligned[k] = acc[k];
        end else begin : g_dly
            logic signed [ACC_W-1:0] dsk_q [DLY];
            logic signed [ACC_W-1:0] dsk_d [DLY];

            always_comb begin
                dsk_d = dsk_q;
                if (en) begin
                    dsk_d[0] = acc[k];
                    for (int j = 1; j < DLY; j++) begin
                        dsk_d[j] = dsk_q[j-1];
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int j = 0; j < DLY; j++) begin
                        dsk_q[j] <= '0;
                    end
                end else begin
                    dsk_q <= dsk_d;
                end
            end

            assign aligned[k] = dsk_q[DLY-1];
        end
    end

    assign unused_tail = ^{ch_first[NUM_PE], ch_data[NUM_PE]};

    // Group FSM and sticky error.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (accept) begin
            state_d = in_last_i ? GRP_IDLE : GRP_OPEN;
            if (((state_q == GRP_IDLE) && !in_first_i) ||
                ((state_q == GRP_OPEN) && in_first_i)) begin
                err_d = 1'b1;
            end
        end
        if (w_we_i && busy) begin
            err_d = 1'b1;
        end
    end

    // done_q marks that the aligned registers now hold a finished group.
    always_comb begin
        done_d      = done_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (en) begin
            done_d      = ch_valid[NUM_PE] & ch_last[NUM_PE];
            out_valid_d = done_q;
            if (done_q) begin
                for (int k = 0; k < NUM_PE; k++) begin
                    out_data_d[k*DATA_W +: DATA_W] = DATA_W'(requant(
                        64'(aligned[k]), int'(cfg_shift_i), cfg_relu_i, DATA_W));
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= GRP_IDLE;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready_o  = en;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule
